// File: rtl/press_arb_pkg.sv
// Shared constants and types for the press arbiter slice.
package press_arb_pkg;

   localparam int MAX_PLAYERS   = 8;
   localparam int HOLDOFF_CNT_W = 4;

   typedef logic [2:0]               player_id_t;
   typedef logic [HOLDOFF_CNT_W-1:0] holdoff_cnt_t;

endpackage

// File: rtl/press_holdoff.sv
// Per-player hold-off counter: reloads on a grant, counts down to zero, locks while non-zero.
module press_holdoff
   import press_arb_pkg::*;
#(
   parameter int HOLDOFF = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec_en,
   output logic lock
);

   holdoff_cnt_t cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = holdoff_cnt_t'(HOLDOFF);
      end else if (dec_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - holdoff_cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign lock = (cnt_q != '0);

endmodule

// File: rtl/press_arbiter.sv
// Turns player button levels into one-per-press round-robin grant pulses.
// Hold-off lockout is built only when PRESS_ARBITER_HOLDOFF_EN is defined.
module press_arbiter
   import press_arb_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int HOLDOFF   = 4,
   localparam int ID_W     = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_PLAYERS-1:0] press,
   output logic [N_PLAYERS-1:0] grant,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic [N_PLAYERS-1:0] pending
);

   logic [N_PLAYERS-1:0] prev_q, prev_d;
   logic [N_PLAYERS-1:0] pending_q, pending_d;
   logic [N_PLAYERS-1:0] grant_q, grant_d;
   logic [ID_W-1:0]      grant_id_q, grant_id_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;

   logic [N_PLAYERS-1:0] lock;
   logic [N_PLAYERS-1:0] rise;
   logic [N_PLAYERS-1:0] accept;
   logic [N_PLAYERS-1:0] cand;
   logic [N_PLAYERS-1:0] win;
   logic                 win_found;
   logic [ID_W-1:0]      win_idx;

`ifdef PRESS_ARBITER_HOLDOFF_EN
   for (genvar i = 0; i < N_PLAYERS; i++) begin : g_holdoff
      press_holdoff #(
         .HOLDOFF(HOLDOFF)
      ) u_holdoff (
         .clk    (clk),
         .reset  (reset),
         .load   (win[i]),
         .dec_en (1'b1),
         .lock   (lock[i])
      );
   end
`else
   logic unused_holdoff;
   assign unused_holdoff = ^HOLDOFF;
   assign lock = '0;
`endif

   assign rise   = press & ~prev_q;
   assign accept = rise & ~lock & {N_PLAYERS{enable}};
   assign cand   = pending_q & ~lock;

   // Scan from ptr with wrap; first unlocked pending player wins.
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int unsigned off = 0; off < N_PLAYERS; off++) begin
         idx = (32'(ptr_q) + off) % N_PLAYERS;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
      if (!enable) begin
         win_found = 1'b0;
         win_idx   = '0;
      end
      win = win_found ? (N_PLAYERS'(1) << win_idx) : '0;
   end

   always_comb begin
      prev_d     = press;
      // A new press in the grant cycle survives the clear.
      pending_d  = enable ? ((pending_q & ~win) | accept) : '0;
      grant_d    = win;
      grant_id_d = win_idx;
      ptr_d      = ptr_q;
      if (win_found) begin
         ptr_d = ID_W'((32'(win_idx) + 1) % N_PLAYERS);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q     <= '0;
         pending_q  <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
      end else begin
         prev_q     <= prev_d;
         pending_q  <= pending_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = grant_id_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_press_arbiter.sv
// Self-checking bench for press_arbiter (N_PLAYERS=2, HOLDOFF=4), directed scenarios plus randomized run.
module tb_press_arbiter;

   localparam int N  = 2;
   localparam int HO = 4;
`ifdef PRESS_ARBITER_HOLDOFF_EN
   localparam bit HO_EN = 1'b1;
`else
   localparam bit HO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] press;
   logic [1:0] grant;
   logic       grant_valid;
   logic [0:0] grant_id;
   logic [1:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   int m_prev[2];
   int m_pend[2];
   int m_cnt[2];
   int m_ptr;
   int m_win;

   always #5 clk = ~clk;

   press_arbiter #(
      .N_PLAYERS(N),
      .HOLDOFF  (HO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .press       (press),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .pending     (pending)
   );

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_prev[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
      end
      m_ptr = 0;
      m_win = -1;
   endtask

   // One rising edge of the reference behaviour, using the inputs seen at that edge.
   task automatic model_edge(input logic [1:0] p, input logic en);
      int lk[2];
      int np[2];
      int win = -1;
      for (int i = 0; i < N; i++) lk[i] = (HO_EN && m_cnt[i] != 0) ? 1 : 0;
      for (int off = 0; off < N; off++) begin
         int i = (m_ptr + off) % N;
         if (win < 0 && m_pend[i] != 0 && lk[i] == 0) win = i;
      end
      if (!en) win = -1;
      for (int i = 0; i < N; i++) begin
         int r = (p[i] && m_prev[i] == 0) ? 1 : 0;
         if (!en) np[i] = 0;
         else np[i] = ((r != 0 && lk[i] == 0) || (m_pend[i] != 0 && i != win)) ? 1 : 0;
      end
      for (int i = 0; i < N; i++) begin
         if (i == win) m_cnt[i] = HO;
         else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
         m_pend[i] = np[i];
         m_prev[i] = p[i] ? 1 : 0;
      end
      if (win >= 0) m_ptr = (win + 1) % N;
      m_win = win;
   endtask

   task automatic step(input logic [1:0] p, input logic en);
      press  = p;
      enable = en;
      @(posedge clk);
      model_edge(p, en);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 1'b1);
   endtask

   task automatic do_reset(input logic [1:0] p);
      @(negedge clk);
      reset = 1'b0;
      press = p;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; press = 2'b00;
      @(posedge clk); #1;
      n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
      n_tests++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
      n_tests++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b want 0", grant_id); end
      n_tests++; if (pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending: got %b want 00", pending); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_simultaneous();
      idle(1);
      for (int rep = 0; rep < 2; rep++) begin
         step(2'b11, 1'b1);
         n_tests++; if (pending !== 2'b11) begin n_fail++; $display("FAIL simul_pending rep%0d: got %b want 11", rep, pending); end
         n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL simul_early rep%0d: got %b want 00", rep, grant); end
         step(2'b11, 1'b1);
         n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL simul_first rep%0d: got %b want 01", rep, grant); end
         n_tests++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL simul_first_id rep%0d: got %b want 0", rep, grant_id); end
         step(2'b11, 1'b1);
         n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL simul_second rep%0d: got %b want 10", rep, grant); end
         n_tests++; if (grant_id !== 1'b1 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL simul_second_id rep%0d: got id=%b v=%b want id=1 v=1", rep, grant_id, grant_valid); end
         idle(6);
      end
   endtask

   task automatic test_single();
      int extra = 0;
      step(2'b01, 1'b1);
      n_tests++; if (pending !== 2'b01 || grant !== 2'b00) begin n_fail++; $display("FAIL single_pending: got p=%b g=%b want p=01 g=00", pending, grant); end
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b01 || grant_id !== 1'b0 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_grant: got g=%b id=%b v=%b want g=01 id=0 v=1", grant, grant_id, grant_valid); end
      n_tests++; if (pending !== 2'b00) begin n_fail++; $display("FAIL single_clear: got %b want 00", pending); end
      for (int i = 0; i < 8; i++) begin
         step(2'b01, 1'b1);
         if (grant !== 2'b00) extra++;
      end
      n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL single_extra: got %0d extra grants want 0", extra); end
      idle(6);
   endtask

   task automatic test_holdoff();
      logic [1:0] want_g3 = HO_EN ? 2'b00 : 2'b01;
      step(2'b01, 1'b1);
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL holdoff_first: got %b want 01", grant); end
      step(2'b00, 1'b1);
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL holdoff_g2: got %b want 00", grant); end
      step(2'b01, 1'b1);
      n_tests++; if (grant !== want_g3) begin n_fail++; $display("FAIL holdoff_g3: got %b want %b", grant, want_g3); end
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL holdoff_g4: got %b want 00", grant); end
      step(2'b00, 1'b1);
      step(2'b01, 1'b1);
      n_tests++; if (pending !== 2'b01) begin n_fail++; $display("FAIL holdoff_repress_pending: got %b want 01", pending); end
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL holdoff_repress_grant: got %b want 01", grant); end
      idle(6);
   endtask

   task automatic test_coalesce();
      int cnt1 = 0;
      int want = HO_EN ? 2 : 3;
      step(2'b10, 1'b1);
      step(2'b10, 1'b1);
      idle(6);
      step(2'b11, 1'b1);
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL coalesce_p0: got %b want 01", grant); end
      for (int k = 0; k < 10; k++) begin
         step((k == 1) ? 2'b01 : 2'b11, 1'b1);
         if (grant === 2'b10) cnt1++;
      end
      n_tests++; if (cnt1 !== want) begin n_fail++; $display("FAIL coalesce_count: got %0d want %0d", cnt1, want); end
      n_tests++; if (pending !== 2'b00) begin n_fail++; $display("FAIL coalesce_pending: got %b want 00", pending); end
      idle(6);
   endtask

   task automatic test_enable();
      step(2'b01, 1'b1);
      n_tests++; if (pending !== 2'b01) begin n_fail++; $display("FAIL enable_pending: got %b want 01", pending); end
      step(2'b01, 1'b0);
      n_tests++; if (pending !== 2'b00 || grant !== 2'b00) begin n_fail++; $display("FAIL enable_flush: got p=%b g=%b want p=00 g=00", pending, grant); end
      step(2'b01, 1'b1);
      n_tests++; if (pending !== 2'b00 || grant !== 2'b00) begin n_fail++; $display("FAIL enable_held1: got p=%b g=%b want 00/00", pending, grant); end
      step(2'b01, 1'b1);
      n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL enable_held2: got %b want 00", grant); end
      idle(2);
   endtask

   task automatic test_async_reset();
      step(2'b10, 1'b1);
      step(2'b10, 1'b1);
      n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL areset_pre: got %b want 10", grant); end
      #2 reset = 1'b0;
      #1;
      n_tests++; if (grant !== 2'b00 || grant_valid !== 1'b0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL areset_grant: got g=%b v=%b id=%b want 00/0/0", grant, grant_valid, grant_id); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      idle(6);
      step(2'b11, 1'b1);
      step(2'b11, 1'b1);
      n_tests++; if (grant !== 2'b01 || pending !== 2'b10) begin n_fail++; $display("FAIL areset_setup: got g=%b p=%b want 01/10", grant, pending); end
      #2 reset = 1'b0;
      #1;
      n_tests++; if (pending !== 2'b00 || grant !== 2'b00) begin n_fail++; $display("FAIL areset_mid: got p=%b g=%b want 00/00", pending, grant); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      step(2'b11, 1'b1);
      n_tests++; if (pending !== 2'b11) begin n_fail++; $display("FAIL areset_held_rise: got %b want 11", pending); end
      step(2'b11, 1'b1);
      n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL areset_ptr: got %b want 01", grant); end
      step(2'b11, 1'b1);
      n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL areset_second: got %b want 10", grant); end
      idle(6);
   endtask

   task automatic test_random();
      logic [1:0] p = 2'b00;
      logic       en;
      logic [1:0] eg, ep;
      logic [0:0] eid;
      do_reset(2'b00);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) p[i] = ~p[i];
         en = ($urandom_range(0, 9) != 0);
         step(p, en);
         eg  = (m_win >= 0) ? (2'b01 << m_win) : 2'b00;
         eid = (m_win >= 0) ? 1'(m_win) : 1'b0;
         for (int i = 0; i < N; i++) ep[i] = (m_pend[i] != 0);
         n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant, eg); end
         n_tests++; if (grant_id !== eid) begin n_fail++; $display("FAIL rand_id c%0d: got %b want %b", c, grant_id, eid); end
         n_tests++; if (grant_valid !== (eg != 2'b00)) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, grant_valid, (eg != 2'b00)); end
         n_tests++; if (pending !== ep) begin n_fail++; $display("FAIL rand_pending c%0d: got %b want %b", c, pending, ep); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_simultaneous();
      test_single();
      test_holdoff();
      test_coalesce();
      test_enable();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/press_arbiter.md
# press_arbiter

Turns synchronized player button levels into one-cycle, one-per-press grant pulses. Shares the single "move" input of the game logic between N players. Sits between the per-player input buffers and the game FSM. Each press is reported exactly once. Simultaneous presses are serialized round-robin. An optional per-player hold-off suppresses re-triggers shortly after a grant.

## Interface
Parameters:
- N_PLAYERS, default 2: number of requesters, legal range 2..8.
- HOLDOFF, default 4: cycles a player is locked after its grant; 0 means no lockout.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  game round active; 0 flushes pending presses and blocks grants.
- press  in  N_PLAYERS  synchronized button levels, one bit per player.
- grant  out  N_PLAYERS  registered one-hot pulse; the granted player's move for this cycle.
- grant_valid  out  1  OR of grant.
- grant_id  out  ID_W  index of the granted player, valid when grant_valid=1, else 0. ID_W = max(1, clog2(N_PLAYERS)).
- pending  out  N_PLAYERS  registered per-player outstanding-press flags.

## Operation
- prev[i] registers press[i] every cycle, regardless of enable.
- rise[i] = press[i] & ~prev[i].
- pending[i] is set by an accepted rise[i] and cleared when player i is granted.
  - Set wins over clear in the same cycle: a new press arriving as the old one is granted stays pending.
  - A rise while pending[i]=1 coalesces; at most one press is outstanding per player.
- A rise is accepted only if enable=1 and lock[i]=0.
- Arbitration, each cycle:
  - Candidates = pending & ~lock.
  - Pick the first candidate scanning i = ptr, ptr+1, … wrapping modulo N_PLAYERS.
  - Register the one-hot winner into grant and its index into grant_id.
  - At most one grant per cycle.
- Pointer update: ptr <= (winner+1) mod N_PLAYERS on a grant; unchanged otherwise.
- Hold-off: on grant to i, lock counter cnt[i] <= HOLDOFF. cnt[i] decrements to 0 and saturates there; lock[i] = (cnt[i] != 0).
- enable=0:
  - pending forced to 0 and grant forced to 0 at the next edge.
  - Counters keep decrementing; ptr holds.
  - A button held across enable rising produces no rise, so no grant.
- Reset asserted, at any time including mid-grant: immediately grant=0, grant_id=0, grant_valid=0, pending=0, prev=0, cnt=0, ptr=0.
- Reset release: the first edge after release samples normally. A button held through reset is seen as a rise.

## Timing
- press[i] first sampled high at edge k → pending[i]=1 after edge k.
- Uncontested press → grant[i]=1 for exactly the cycle after edge k+1. Latency is 2 edges.
- Contended players are granted on consecutive cycles in round-robin order.
- Worst-case wait is N_PLAYERS-1 extra cycles (no hold-off interaction).
- Lock is active for HOLDOFF cycles after the grant edge. A rise sampled at edge g+HOLDOFF+1 or later is accepted, where g is the grant edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PRESS_ARBITER_HOLDOFF_EN defined: cnt/lock logic is present as described.
- Not defined:
  - No counters are built; lock is constant 0.
  - HOLDOFF is ignored.
  - Every rise is accepted while enable=1; all other behavior is identical.

## Structure
- Package press_arb_pkg holds:
  - MAX_PLAYERS = 8.
  - Localparam for the hold-off counter width (4 bits; HOLDOFF ≤ 15).
  - typedef player_id_t (3 bits, sized for MAX_PLAYERS).
- Sub-module press_holdoff, one instance per player:
  - Inputs: load pulse and enable.
  - Output: lock.
  - Contains the counter; only instantiated under PRESS_ARBITER_HOLDOFF_EN.
- Edge detection, pending, pointer and round-robin selection stay in press_arbiter.

## Test plan
All scenarios use N_PLAYERS=2, HOLDOFF=4, enable=1 unless stated.
- Single press: press=01 from edge 3, held 10 cycles → exactly one grant=01 pulse in the cycle after edge 4; grant_id=0; no further grants.
- Simultaneous, ptr=0: press=11 at edge k → grant=01 after k+1, grant=10 after k+2. Repeat after release → the same order 01 then 10, since ptr has wrapped to 0.
- Hold-off: player 0 granted at edge g, re-pressed at g+2 → no grant. Released and re-pressed at g+6 → grant=01 two edges later. With the macro undefined, the re-press at g+2 is granted.
- Coalescing: player 1 blocked behind a player 0 grant, toggles press 1→0→1 while pending → exactly one grant=10.
- Enable: pending=01 then enable=0 for 1 cycle → pending=00, no grant. Button held while enable rises → no grant.
- Async reset: reset=0 mid-cycle while grant=10 → grant, pending, grant_valid drop to 0 before the next clk edge. After release, ptr=0 (simultaneous press grants player 0 first).
